bus_slave_responder: RTL

Slave-side responder for the 3-master round-robin shared bus; one instance sits behind each of the arbiter's two slave-select lines. It accepts the granted master's command and services it against a local register file after a programmable number of wait states. It returns a single-cycle ack pulse; the high-then-low ack edge is what the arbiter treats as command-done to advance its grant. It holds off new commands until the master withdraws the current one.

---
 rtl/bus_slave_responder.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/bus_slave_responder.sv
// rtl/bus_slave_responder.sv - shared-bus slave responder with wait states and a local register file
module bus_slave_responder #(
  parameter int                ADDR_W   = 4,
  parameter int                DATA_W   = 32,
  parameter int                WAIT_CYC = 2,
  parameter logic [DATA_W-1:0] ID_VAL   = 32'h0000_5A01
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sel,
  input  logic              valid,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ack,
  output logic              err,
  output logic [DATA_W-1:0] rdata,
  output logic              busy
);

  localparam int         DEPTH   = 2 ** ADDR_W;
  localparam logic [3:0] LP_WAIT = 4'(WAIT_CYC);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [3:0]          r_cnt;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic                r_ack;
  logic                r_err;
  logic [DATA_W-1:0]   r_rdata;
  logic                w_busy;

  logic                w_start;
  logic                w_commit;
  logic                w_cmd_we;
  logic [ADDR_W-1:0]   w_cmd_addr;
  logic [DATA_W-1:0]   w_cmd_wdata;
  logic                w_cmd_is_id;

  // A command is accepted only from IDLE and only when this slave is selected.
  assign w_start  = (r_state == S_IDLE) && sel && valid;

  // The commit happens on the edge that enters ACK, from either IDLE or WAIT.
  assign w_commit = (r_state != S_ACK) && (w_next == S_ACK);

  // With zero wait states the commit coincides with capture, so use the live bus.
  assign w_cmd_we    = (r_state == S_IDLE) ? we    : r_we;
  assign w_cmd_addr  = (r_state == S_IDLE) ? addr  : r_addr;
  assign w_cmd_wdata = (r_state == S_IDLE) ? wdata : r_wdata;
  assign w_cmd_is_id = (w_cmd_addr == '0);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; DONE waits for the master to withdraw so a held valid is serviced once.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_next = (LP_WAIT == 4'd0) ? S_ACK : S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_cnt <= 4'd1) begin
          w_next = S_ACK;
        end
      end
      S_ACK:  w_next = S_DONE;
      S_DONE: begin
        if (!valid || !sel) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Output decode from state.
  always_comb begin
    w_busy = 1'b0;
    if (r_state != S_IDLE) begin
      w_busy = 1'b1;
    end
  end

  // Command capture and wait-state countdown; later bus changes are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_start) begin
      r_cnt   <= LP_WAIT;
      r_we    <= we;
      r_addr  <= addr;
      r_wdata <= wdata;
    end else if (r_state == S_WAIT) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  // Register file; word 0 is the read-only ID and is never written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_commit && w_cmd_we && !w_cmd_is_id) begin
      r_mem[w_cmd_addr] <= w_cmd_wdata;
    end
  end

  // Response registers: one-cycle ack, err on ID writes, read data held after ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ack <= w_commit;
      r_err <= w_commit && w_cmd_we && w_cmd_is_id;
      if (w_commit && !w_cmd_we) begin
        r_rdata <= w_cmd_is_id ? ID_VAL : r_mem[w_cmd_addr];
      end
    end
  end

  assign ack   = r_ack;
  assign err   = r_err;
  assign rdata = r_rdata;
  assign busy  = w_busy;

endmodule
